// File: rtl/mem_line_master.sv
// mem_line_master: cache-side initiator for the shared C2 memory bus.
// Takes one whole-line read or write from the cache controller and runs it on
// the tri-state C2 bus. A write is the command plus data beats. A read is a
// single command cycle, then the line beats returned by the memory. Completion
// is reported to the cache with a one-cycle rsp_valid pulse.
// Optional feature: define C2_MASTER_TIMEOUT_EN to add a response timeout.
// A timeout is reported on an extra rsp_err port.
module mem_line_master #(
    parameter int LINE_BYTES     = 16,
    parameter int BUS_BYTES      = 2,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LINE_BYTES*8-1:0] req_wdata,
    output logic                    rsp_valid,
`ifdef C2_MASTER_TIMEOUT_EN
    output logic                    rsp_err,
`endif
    output logic [LINE_BYTES*8-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]       bus_addr,
    inout  wire  [BUS_BYTES*8-1:0]  bus_data,
    inout  wire  [1:0]              bus_cmd
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BUS_W  = BUS_BYTES * 8;
    localparam int BEATS  = LINE_BYTES / BUS_BYTES;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int OFF_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    localparam logic [CNT_W-1:0] BEATS_CNT = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // C2 command encodings shared with the memory side
    localparam logic [1:0] C2_NOP        = 2'b00;
    localparam logic [1:0] C2_RESPONSE   = 2'b01;
    localparam logic [1:0] C2_READ_LINE  = 2'b10;
    localparam logic [1:0] C2_WRITE_LINE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_BEATS,
        WR_WAIT,
        RD_CMD,
        RD_WAIT,
        RD_BEATS
    } state_t;

    state_t             state;
    logic               owner;
    logic [1:0]         cmd_q;
    logic [BUS_W-1:0]   data_q;
    logic [CNT_W-1:0]   beat_cnt;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  line_buf;
    logic [LINE_W-1:0]  line_capture;
    logic [OFF_W-1:0]   beat_off;
    logic               resp_seen;

`ifdef C2_MASTER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0]  wait_cnt;
`endif

    // The bus is driven only while this master owns it.
    assign bus_cmd   = owner ? cmd_q  : 2'bzz;
    assign bus_data  = owner ? data_q : {BUS_W{1'bz}};
    assign req_ready = (state == IDLE);
    assign beat_off  = OFF_W'(beat_cnt * BUS_W);
    // NOP, Z and X on the command wires all fail this compare and are ignored.
    assign resp_seen = (bus_cmd == C2_RESPONSE);

    // Current line buffer with the beat on the bus merged in at beat_cnt.
    always_comb begin
        line_capture = line_buf;
        line_capture[beat_off +: BUS_W] = bus_data;
    end

    // Control FSM: ownership, command, beat sequencing and the completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            cmd_q     <= C2_NOP;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            bus_addr  <= '0;
            beat_cnt  <= '0;
`ifdef C2_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef C2_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        bus_addr <= req_addr;
                        owner    <= 1'b1;
                        if (req_write) begin
                            state    <= WR_BEATS;
                            cmd_q    <= C2_WRITE_LINE;
                            beat_cnt <= CNT_W'(1);
                        end else begin
                            state    <= RD_CMD;
                            cmd_q    <= C2_READ_LINE;
                            beat_cnt <= '0;
                        end
                    end
                end
                WR_BEATS: begin
                    cmd_q <= C2_NOP;
                    if (beat_cnt == BEATS_CNT) begin
                        owner    <= 1'b0;
                        beat_cnt <= '0;
                        state    <= WR_WAIT;
`ifdef C2_MASTER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                RD_CMD: begin
                    owner    <= 1'b0;
                    cmd_q    <= C2_NOP;
                    beat_cnt <= '0;
                    state    <= RD_WAIT;
`ifdef C2_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WR_WAIT: begin
                    if (resp_seen) begin
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end
`ifdef C2_MASTER_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                RD_WAIT: begin
                    // The response cycle already carries beat 0.
                    if (resp_seen) begin
                        if (beat_cnt == LAST_BEAT) begin
                            rsp_rdata <= line_capture;
                            rsp_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            state    <= RD_BEATS;
                        end
                    end
`ifdef C2_MASTER_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                RD_BEATS: begin
                    if (beat_cnt == LAST_BEAT) begin
                        rsp_rdata <= line_capture;
                        rsp_valid <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    owner <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath: latched write line, outgoing beat and incoming line buffer.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (req_valid) begin
                    wdata_q <= req_wdata;
                    data_q  <= req_write ? req_wdata[BUS_W-1:0] : '0;
                end
            end
            WR_BEATS: begin
                if (beat_cnt != BEATS_CNT) begin
                    data_q <= wdata_q[beat_off +: BUS_W];
                end
            end
            RD_WAIT: begin
                if (resp_seen) begin
                    line_buf <= line_capture;
                end
            end
            RD_BEATS: begin
                line_buf <= line_capture;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mem_line_master.md
Name: mem_line_master

Overview:
- Cache-side initiator for the C2 memory bus.
- Accepts one whole-line read or write request from the cache controller and runs it on the shared tri-state C2 bus: cmd, address, then data beats.
- Waits for the memory's C2_RESPONSE, then returns completion (and, for reads, the assembled line) to the cache.
- Sits between the cache line-fill/eviction logic and the shared cmd/data wires.

Parameters:
- LINE_BYTES, 16, bytes per cache line (= cache_line_size).
- BUS_BYTES, 2, bytes per data beat (= data2_bus_size); LINE_BYTES must be a multiple of it; BEATS = LINE_BYTES/BUS_BYTES.
- ADDR_W, 16, line-address width (= addr2_bus_size*BITS_IN_BYTE).
- TIMEOUT_CYCLES, 255, response wait limit; used only with C2_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  bus clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high exactly when state is IDLE.
- req_write  in  1  1 = write line, 0 = read line.
- req_addr  in  ADDR_W  line address.
- req_wdata  in  LINE_BYTES*8  line to write; byte b at bits [b*8+:8].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  LINE_BYTES*8  read line, same byte layout; held until the next read completes.
- bus_addr  out  ADDR_W  C2 address.
- bus_data  inout  BUS_BYTES*8  C2 data; Z when not owned.
- bus_cmd  inout  2  C2 command (C2_NOP/C2_RESPONSE/C2_READ_LINE/C2_WRITE_LINE from parameters.sv); Z when not owned.

Behaviour:
- Reset (async): state=IDLE, owner=0 (bus_cmd/bus_data = Z), rsp_valid=0, rsp_rdata=0, bus_addr=0, beat counter=0, wait counter=0.
- Clocking: all logic on posedge clk. Beat k carries line bytes k*BUS_BYTES .. k*BUS_BYTES+BUS_BYTES-1; byte j of a beat sits at bus bits [j*8+:8].
- IDLE: on req_valid at a posedge, latch addr, wdata and write. Drive bus_addr; hold it stable until the transaction completes.
- Write path:
  - WR_BEATS: BEATS consecutive cycles with owner=1, one beat per cycle, starting at beat 0.
  - bus_cmd = C2_WRITE_LINE in the first beat cycle only, C2_NOP in the remaining beats.
  - After the last beat cycle, owner=0 and go to WR_WAIT.
- Read path:
  - RD_CMD: exactly one cycle with owner=1, bus_cmd = C2_READ_LINE, bus_data = 0.
  - Then owner=0 and go to RD_WAIT.
- WR_WAIT: sample bus_cmd each posedge. On C2_RESPONSE, assert rsp_valid for one cycle and go to IDLE.
- RD_WAIT: sample bus_cmd each posedge. On C2_RESPONSE, capture bus_data as beat 0 at that same edge and go to RD_BEATS.
- RD_BEATS: capture one beat per posedge until BEATS beats are captured. After the last capture, update rsp_rdata, pulse rsp_valid and go to IDLE.
- Wait states: C2_NOP, Z or X on bus_cmd are ignored.
- rsp_valid: registered; it is high in the first cycle back in IDLE. req_ready is also high in that cycle, so back-to-back accept is legal.
- Master never drives the bus in IDLE, *_WAIT or RD_BEATS. Bus contention in those states is a responder error.
- req_valid while not IDLE is ignored; no queueing.
- Reset mid-transaction: bus released immediately, transaction dropped, no rsp_valid, rsp_rdata unchanged from reset value.
- Write bus occupancy is exactly BEATS cycles. Read command occupancy is exactly 1 cycle.

Optional Feature:
- Macro: C2_MASTER_TIMEOUT_EN.
- With it:
  - Wait counter clears on entry to WR_WAIT/RD_WAIT and increments each cycle spent there.
  - If it reaches TIMEOUT_CYCLES with no C2_RESPONSE: pulse rsp_valid with extra output port rsp_err=1, rsp_rdata unchanged, go to IDLE.
  - rsp_err is 0 on every normal completion and on reset.
- Without it: no rsp_err port, no counter; the wait states hold indefinitely.

Test Plan:
- Write to addr 0x0005, line bytes = index 0..15, defaults, responder answers C2_RESPONSE 10 cycles after the last beat -> 8 beats 0x0100, 0x0302, ... 0x0F0E on consecutive cycles; C2_WRITE_LINE only on beat 0; bus Z afterwards; one rsp_valid.
- Read addr 0x0003, responder returns beats 0xA1A0 .. 0xAFAE after 7 NOP cycles -> single C2_READ_LINE cycle; rsp_rdata byte b = 0xA0+b; rsp_valid exactly one cycle after the last beat capture.
- Back-to-back: read accepted in the rsp_valid cycle of a preceding write -> READ_LINE issued the next cycle; no gap and no overlap in bus ownership.
- req_valid pulsed during RD_WAIT -> ignored, req_ready=0, no second command on the bus.
- Reset asserted in WR_BEATS beat 3 -> bus_cmd/bus_data Z in the same cycle; no rsp_valid; next request starts cleanly.
- With C2_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=20, responder silent -> rsp_valid with rsp_err=1 after 20 wait cycles; without the macro, the block stays in RD_WAIT.
